ransac_memory_read_arbiter: RTL and testbench

- Shares the single memory AXI-Lite read channel (AR/R) between `requester_count` internal point-fetch requesters, e.g. the plane check units and the sampler.
- Arbitrates AR with round-robin priority.
- Records which requester owns each outstanding read in an in-order tag FIFO, and routes R beats back to that requester.
- Sits between the requesters and the memory_ar*/memory_r* ports of the RANSAC unit top level. The AW/W/B channels are not touched.

---
 rtl/ransac_memory_read_arbiter.sv | 127 ++++++++++++
 tb/tb_ransac_memory_read_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ransac_memory_read_arbiter.sv
// Round-robin share of one AXI-Lite AR/R channel; AR issue lands 1 cycle after accept, R is a combinational pass-through.
// Backpressure: a grant needs a free AR slot and a free tag after this cycle's pop; R stalls follow the head owner's rready.
module ransac_memory_read_arbiter #(
  parameter int requester_count   = 2,
  parameter int memory_addr_width = 32,
  parameter int memory_data_width = 32,
  parameter int max_outstanding   = 8
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [requester_count*memory_addr_width-1:0] req_araddr,
  input  logic [requester_count-1:0]                   req_arvalid,
  output logic [requester_count-1:0]                   req_arready,
  output logic [memory_data_width-1:0]                 req_rdata,
  output logic [1:0]                                   req_rresp,
  output logic [requester_count-1:0]                   req_rvalid,
  input  logic [requester_count-1:0]                   req_rready,
  output logic [memory_addr_width-1:0]                 memory_araddr,
  output logic                                         memory_arvalid,
  input  logic                                         memory_arready,
  input  logic [memory_data_width-1:0]                 memory_rdata,
  input  logic [1:0]                                   memory_rresp,
  input  logic                                         memory_rvalid,
  output logic                                         memory_rready,
  output logic [$clog2(max_outstanding):0]             outstanding_count,
  output logic                                         unexpected_response
);

  localparam int tag_width   = (requester_count > 1) ? $clog2(requester_count) : 1;
  localparam int ptr_width   = $clog2(max_outstanding);
  localparam int count_width = ptr_width + 1;

  typedef enum logic {ar_idle, ar_issue} ar_state_t;

  ar_state_t state, state_next;

  logic [tag_width-1:0]         tag_mem [max_outstanding];
  logic [ptr_width-1:0]         wr_ptr, rd_ptr;
  logic [count_width-1:0]       count, count_after_pop;
  logic [tag_width-1:0]         rr_ptr, grant_idx, head, idx;
  logic [requester_count-1:0]   grant;
  logic [memory_addr_width-1:0] addr_arr [requester_count];
  logic                         fifo_empty, fifo_room, can_issue, accept, pop;

  for (genvar g = 0; g < requester_count; g++) begin : g_addr
    assign addr_arr[g] = req_araddr[g*memory_addr_width +: memory_addr_width];
  end

  assign head       = tag_mem[rd_ptr];
  assign fifo_empty = (count == '0);

  // R beats go only to the owner of the oldest outstanding read.
  always_comb begin
    req_rvalid    = '0;
    memory_rready = 1'b0;
    if (!fifo_empty) begin
      req_rvalid[head] = memory_rvalid;
      memory_rready    = req_rready[head];
    end
  end

  assign req_rdata = memory_rdata;
  assign req_rresp = memory_rresp;
  assign pop       = !fifo_empty && memory_rvalid && memory_rready;

  // A slot freed by this cycle's pop can be reused immediately.
  assign count_after_pop = count - count_width'(pop);
  assign fifo_room       = count_after_pop < count_width'(max_outstanding);
  assign can_issue       = (state == ar_idle) || memory_arready;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    if (can_issue && fifo_room) begin
      for (int k = 0; k < requester_count; k++) begin
        idx = tag_width'((int'(rr_ptr) + k) % requester_count);
        if (grant == '0 && req_arvalid[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = idx;
        end
      end
    end
  end

  assign req_arready = grant;
  assign accept      = |grant;

  always_comb begin
    state_next = state;
    case (state)
      ar_idle:  if (accept) state_next = ar_issue;
      ar_issue: if (!accept && memory_arready) state_next = ar_idle;
      default:  state_next = ar_idle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= ar_idle;
      memory_araddr       <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      rr_ptr              <= '0;
      unexpected_response <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        memory_araddr <= addr_arr[grant_idx];
        wr_ptr        <= wr_ptr + 1'b1;
        rr_ptr        <= (int'(grant_idx) == requester_count - 1) ? '0 : grant_idx + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + count_width'(accept) - count_width'(pop);
      if (fifo_empty && memory_rvalid) unexpected_response <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) tag_mem[wr_ptr] <= grant_idx;
  end

  assign memory_arvalid    = (state == ar_issue);
  assign outstanding_count = count;

endmodule

// File: tb/tb_ransac_memory_read_arbiter.sv
// Directed bench for ransac_memory_read_arbiter: per-cycle vector table plus hand-written multi-cycle corner cases.
module tb_ransac_memory_read_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] a0, a1;
  logic [63:0] req_araddr;
  logic [1:0]  req_arvalid, req_arready, req_rvalid, req_rready, req_rresp, memory_rresp;
  logic [31:0] req_rdata, memory_araddr, memory_rdata;
  logic        memory_arvalid, memory_arready, memory_rvalid, memory_rready;
  logic [3:0]  outstanding_count;
  logic        unexpected_response;

  int n_cmp = 0;
  int n_fail = 0;
  int grants;

  assign req_araddr = {a1, a0};

  always #5 clock = ~clock;

  ransac_memory_read_arbiter #(
    .requester_count(2), .memory_addr_width(32), .memory_data_width(32), .max_outstanding(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_araddr(req_araddr), .req_arvalid(req_arvalid), .req_arready(req_arready),
    .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rvalid(req_rvalid), .req_rready(req_rready),
    .memory_araddr(memory_araddr), .memory_arvalid(memory_arvalid), .memory_arready(memory_arready),
    .memory_rdata(memory_rdata), .memory_rresp(memory_rresp), .memory_rvalid(memory_rvalid),
    .memory_rready(memory_rready), .outstanding_count(outstanding_count),
    .unexpected_response(unexpected_response)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  arv;
    logic [31:0] addr0, addr1;
    logic        mar, mrv;
    logic [31:0] rdata;
    logic [1:0]  rrdy;
    logic [1:0]  e_arr;
    logic        e_arv;
    logic [31:0] e_ara;
    logic [1:0]  e_rv;
    logic        e_mrr;
    logic [3:0]  e_cnt;
    logic        e_unx;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_arvalid = '0; a0 = '0; a1 = '0; memory_arready = 1'b0;
    memory_rvalid = 1'b0; memory_rdata = '0; memory_rresp = '0; req_rready = '0;
    repeat (2) @(posedge clock);
    #1;

    //         rst arv    a0        a1       mar mrv rdata         rrdy   e_arr  arv e_ara     e_rv  mrr cnt unx
    vecs.push_back('{0, 2'b00, 32'h1000, 32'h0,   0, 0, 32'h0,        2'b11, 2'b00, 0, 32'h0,    2'b00, 0, 0, 0});
    vecs.push_back('{0, 2'b01, 32'h1000, 32'h0,   1, 0, 32'h0,        2'b11, 2'b01, 0, 32'h0,    2'b00, 0, 0, 0});
    vecs.push_back('{0, 2'b00, 32'h1000, 32'h0,   1, 0, 32'h0,        2'b11, 2'b00, 1, 32'h1000, 2'b00, 1, 1, 0});
    vecs.push_back('{0, 2'b00, 32'h1000, 32'h0,   1, 1, 32'hDEADBEEF, 2'b11, 2'b00, 0, 32'h1000, 2'b01, 1, 1, 0});
    vecs.push_back('{0, 2'b00, 32'h1000, 32'h0,   1, 0, 32'h0,        2'b11, 2'b00, 0, 32'h1000, 2'b00, 0, 0, 0});
    vecs.push_back('{1, 2'b00, 32'h1000, 32'h0,   0, 0, 32'h0,        2'b11, 2'b00, 0, 32'h1000, 2'b00, 0, 0, 0});
    vecs.push_back('{0, 2'b11, 32'h100,  32'h200, 1, 0, 32'h0,        2'b11, 2'b01, 0, 32'h0,    2'b00, 0, 0, 0});
    vecs.push_back('{0, 2'b11, 32'h100,  32'h200, 1, 0, 32'h0,        2'b11, 2'b10, 1, 32'h100,  2'b00, 1, 1, 0});
    vecs.push_back('{0, 2'b11, 32'h100,  32'h200, 1, 0, 32'h0,        2'b11, 2'b01, 1, 32'h200,  2'b00, 1, 2, 0});
    vecs.push_back('{0, 2'b11, 32'h100,  32'h200, 1, 0, 32'h0,        2'b11, 2'b10, 1, 32'h100,  2'b00, 1, 3, 0});
    vecs.push_back('{0, 2'b00, 32'h100,  32'h200, 1, 0, 32'h0,        2'b11, 2'b00, 1, 32'h200,  2'b00, 1, 4, 0});
    vecs.push_back('{0, 2'b00, 32'h100,  32'h200, 1, 1, 32'hA1,       2'b11, 2'b00, 0, 32'h200,  2'b01, 1, 4, 0});
    vecs.push_back('{0, 2'b00, 32'h100,  32'h200, 1, 1, 32'hA2,       2'b11, 2'b00, 0, 32'h200,  2'b10, 1, 3, 0});
    vecs.push_back('{0, 2'b00, 32'h100,  32'h200, 1, 1, 32'hA3,       2'b11, 2'b00, 0, 32'h200,  2'b01, 1, 2, 0});
    vecs.push_back('{0, 2'b00, 32'h100,  32'h200, 1, 1, 32'hA4,       2'b11, 2'b00, 0, 32'h200,  2'b10, 1, 1, 0});
    vecs.push_back('{0, 2'b00, 32'h100,  32'h200, 1, 0, 32'h0,        2'b11, 2'b00, 0, 32'h200,  2'b00, 0, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; req_arvalid = vecs[i].arv; a0 = vecs[i].addr0; a1 = vecs[i].addr1;
      memory_arready = vecs[i].mar; memory_rvalid = vecs[i].mrv; memory_rdata = vecs[i].rdata;
      req_rready = vecs[i].rrdy;
      #4;
      chk($sformatf("v%0d_arready", i), 32'(req_arready), 32'(vecs[i].e_arr));
      chk($sformatf("v%0d_arvalid", i), 32'(memory_arvalid), 32'(vecs[i].e_arv));
      chk($sformatf("v%0d_araddr", i), memory_araddr, vecs[i].e_ara);
      chk($sformatf("v%0d_rvalid", i), 32'(req_rvalid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d_rready", i), 32'(memory_rready), 32'(vecs[i].e_mrr));
      chk($sformatf("v%0d_count", i), 32'(outstanding_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_unexp", i), 32'(unexpected_response), 32'(vecs[i].e_unx));
      if (vecs[i].e_rv != 2'b00) chk($sformatf("v%0d_rdata", i), req_rdata, vecs[i].rdata);
      next_cycle();
    end

    // AR backpressure: address held while memory stalls, a single handshake on release.
    reset = 1'b0; req_arvalid = 2'b01; a0 = 32'h300; a1 = 32'h400;
    memory_arready = 1'b0; memory_rvalid = 1'b0; req_rready = 2'b11;
    #4; chk("bp_grant", 32'(req_arready), 32'h1);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      req_arvalid = 2'b10;
      #4;
      chk("bp_arready", 32'(req_arready), 32'h0);
      chk("bp_arvalid", 32'(memory_arvalid), 32'h1);
      chk("bp_araddr", memory_araddr, 32'h300);
      next_cycle();
    end
    req_arvalid = 2'b00; memory_arready = 1'b1;
    #4; chk("bp_release_arvalid", 32'(memory_arvalid), 32'h1);
    next_cycle();
    memory_rvalid = 1'b1; memory_rdata = 32'h33;
    #4;
    chk("bp_one_issue", 32'(memory_arvalid), 32'h0);
    chk("bp_count", 32'(outstanding_count), 32'h1);
    chk("bp_rvalid", 32'(req_rvalid), 32'h1);
    next_cycle();
    memory_rvalid = 1'b0;
    #4; chk("bp_drained", 32'(outstanding_count), 32'h0);
    next_cycle();

    // Fill the tag FIFO: 10 cycles of offered requests, only 8 fit.
    req_arvalid = 2'b11; a0 = 32'h500; a1 = 32'h600; memory_arready = 1'b1;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      #4;
      if (req_arready != 2'b00) grants++;
      next_cycle();
    end
    chk("full_accepts", 32'(grants), 32'd8);
    #4;
    chk("full_arready", 32'(req_arready), 32'h0);
    chk("full_count", 32'(outstanding_count), 32'h8);
    next_cycle();
    memory_rvalid = 1'b1; memory_rdata = 32'h77;
    #4;
    chk("full_pop_grant", 32'(req_arready), 32'h2);
    chk("full_pop_rvalid", 32'(req_rvalid), 32'h2);
    chk("full_pop_rready", 32'(memory_rready), 32'h1);
    next_cycle();
    memory_rvalid = 1'b0; req_arvalid = 2'b00;
    #4; chk("full_push_pop_count", 32'(outstanding_count), 32'h8);
    next_cycle();

    // Head owner (requester 0) stalls its R channel.
    for (int i = 0; i < 3; i++) begin
      memory_rvalid = 1'b1; memory_rdata = 32'h55; memory_rresp = 2'b10; req_rready = 2'b10;
      #4;
      chk("stall_mrready", 32'(memory_rready), 32'h0);
      chk("stall_rvalid", 32'(req_rvalid), 32'h1);
      chk("stall_rdata", req_rdata, 32'h55);
      chk("stall_rresp", 32'(req_rresp), 32'h2);
      chk("stall_count", 32'(outstanding_count), 32'h8);
      next_cycle();
    end
    req_rready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      memory_rvalid = 1'b1; memory_rdata = 32'(i);
      #4;
      chk($sformatf("drain%0d_rvalid", i), 32'(req_rvalid), (i % 2 == 0) ? 32'h1 : 32'h2);
      next_cycle();
    end
    memory_rvalid = 1'b0; memory_rresp = 2'b00;
    #4; chk("drain_count", 32'(outstanding_count), 32'h0);
    next_cycle();

    // Response with nothing outstanding, then reset with reads in flight.
    memory_rvalid = 1'b1;
    #4;
    chk("unexp_mrready", 32'(memory_rready), 32'h0);
    chk("unexp_rvalid", 32'(req_rvalid), 32'h0);
    chk("unexp_before", 32'(unexpected_response), 32'h0);
    next_cycle();
    memory_rvalid = 1'b0;
    #4; chk("unexp_set", 32'(unexpected_response), 32'h1);
    next_cycle();
    req_arvalid = 2'b01; a0 = 32'h700; memory_arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("rst_fill_grant", 32'(req_arready), 32'h1);
      chk("unexp_sticky", 32'(unexpected_response), 32'h1);
      next_cycle();
    end
    req_arvalid = 2'b00; reset = 1'b1;
    #4;
    chk("rst_pre_count", 32'(outstanding_count), 32'h3);
    chk("rst_pre_arvalid", 32'(memory_arvalid), 32'h1);
    next_cycle();
    reset = 1'b0; req_arvalid = 2'b11; memory_arready = 1'b0;
    #4;
    chk("rst_arvalid", 32'(memory_arvalid), 32'h0);
    chk("rst_araddr", memory_araddr, 32'h0);
    chk("rst_count", 32'(outstanding_count), 32'h0);
    chk("rst_unexp", 32'(unexpected_response), 32'h0);
    chk("rst_rr_ptr", 32'(req_arready), 32'h1);
    next_cycle();
    req_arvalid = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
